// File: rtl/idwt53_row.sv
// -----------------------------------------------------------------------------
// idwt53_row
//   Inverse 5/3 (Le Gall) integer lifting engine for a single row. Reads an
//   interleaved coefficient row (even = low-pass s, odd = high-pass d) from a
//   synchronous dual-port sample RAM, reconstructs the pixels in place and
//   writes them back.
//
//   Pass 1 restores the even samples:
//     x[i] = c[i] - ((c[i-1] + c[i+1] + 2) >>> 2)      i = 0,2,..,LEN-2
//   Pass 2 restores the odd samples from the already restored evens:
//     x[i] = c[i] + ((x[i-1] + x[i+1]) >>> 1)          i = 1,3,..,LEN-1
//   Row edges use symmetric extension (index -1 -> 1, index LEN -> LEN-2).
//
//   Every sample takes five cycles: RD_L, RD_C, RD_R, CAP, WR. The RAM returns
//   data one cycle after the read enable, so each operand is captured in the
//   state that follows its read.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      1-cycle pulse, begins a row at base_addr (ignored unless idle)
//   base_addr  RAM address of x[0], sampled when start is accepted
//   busy       high from the cycle after an accepted start through the final write
//   done       1-cycle pulse in the cycle after the final write
//   rd_en      RAM read enable
//   rd_addr    RAM read address
//   rd_data    RAM read data, valid the cycle after rd_en
//   wr_en      RAM write enable
//   wr_addr    RAM write address
//   wr_data    RAM write data
// -----------------------------------------------------------------------------
module idwt53_row #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6,
  parameter int LEN    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  // One extra bit so LEN-1 always fits, even for the smallest rows.
  localparam int IDX_W = $clog2(LEN) + 1;

  localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO       = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_LAST_EVEN = IDX_W'(LEN - 2);
  localparam logic [IDX_W-1:0] IDX_LAST_ODD  = IDX_W'(LEN - 1);

  // Rounding offset of the even-sample (update) step.
  localparam logic signed [WIDTH+1:0] PRED_ROUND = (WIDTH + 2)'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_L,
    S_RD_C,
    S_RD_R,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;       // centre sample index within the row
  logic                odd_q, odd_d;       // 0: pass 1 (evens), 1: pass 2 (odds)
  logic [ADDR_W-1:0]   base_q, base_d;     // row base captured at start

  logic [WIDTH-1:0]    left_q;             // neighbour at index-1 (mirrored)
  logic [WIDTH-1:0]    cent_q;             // coefficient being reconstructed
  logic [WIDTH-1:0]    right_q;            // neighbour at index+1 (mirrored)

  logic [IDX_W-1:0]    left_idx;
  logic [IDX_W-1:0]    right_idx;
  logic [WIDTH-1:0]    result;

  // ---------------------------------------------------------------------------
  // Neighbour indices with symmetric extension. Index 0 only occurs in pass 1,
  // where its left neighbour mirrors to 1; index LEN-1 only occurs in pass 2,
  // where its right neighbour mirrors to LEN-2.
  // ---------------------------------------------------------------------------
  always_comb begin
    left_idx  = (idx_q == '0)           ? IDX_ONE       : idx_q - IDX_ONE;
    right_idx = (idx_q == IDX_LAST_ODD) ? IDX_LAST_EVEN : idx_q + IDX_ONE;
  end

  // Row index to RAM address; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

  // ---------------------------------------------------------------------------
  // Lifting datapath. Operands are sign-extended by two bits so the neighbour
  // sum plus rounding cannot overflow; >>> on signed operands floors. The final
  // cast keeps the low WIDTH bits, so out-of-range results wrap.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH+1:0] left_x, cent_x, right_x, pair_x;

  always_comb begin
    left_x  = {{2{left_q[WIDTH-1]}},  left_q};
    cent_x  = {{2{cent_q[WIDTH-1]}},  cent_q};
    right_x = {{2{right_q[WIDTH-1]}}, right_q};
    pair_x  = left_x + right_x;
    if (odd_q) begin
      result = WIDTH'(cent_x + (pair_x >>> 1));
    end else begin
      result = WIDTH'(cent_x - ((pair_x + PRED_ROUND) >>> 2));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; an unassigned path in combinational logic infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    odd_d   = odd_q;
    base_d  = base_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_L;
          idx_d   = '0;
          odd_d   = 1'b0;
          base_d  = base_addr;
        end
      end
      S_RD_L: state_d = S_RD_C;
      S_RD_C: state_d = S_RD_R;
      S_RD_R: state_d = S_CAP;
      S_CAP:  state_d = S_WR;
      S_WR: begin
        if (!odd_q && (idx_q == IDX_LAST_EVEN)) begin
          // Evens finished: odd pass starts at index 1. Its first read follows
          // this write by a full cycle, so it sees the restored even sample.
          state_d = S_RD_L;
          odd_d   = 1'b1;
          idx_d   = IDX_ONE;
        end else if (odd_q && (idx_q == IDX_LAST_ODD)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD_L;
          idx_d   = idx_q + IDX_TWO;
        end
      end
      // Start is not looked at here, so a pulse during DONE is dropped.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM and status outputs, decoded from the registered state. IDLE drives
  // all zeros, which is also the reset value of every output.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    unique case (state_q)
      S_RD_L: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = row_addr(base_q, left_idx);
      end
      S_RD_C: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = row_addr(base_q, idx_q);
      end
      S_RD_R: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = row_addr(base_q, right_idx);
      end
      S_CAP: begin
        busy = 1'b1;
      end
      S_WR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = row_addr(base_q, idx_q);
        wr_data = result;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      odd_q   <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      odd_q   <= odd_d;
      base_q  <= base_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture: each read returns data in the following state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_q  <= '0;
      cent_q  <= '0;
      right_q <= '0;
    end else begin
      unique case (state_q)
        S_RD_C:  left_q  <= rd_data;
        S_RD_R:  cent_q  <= rd_data;
        S_CAP:   right_q <= rd_data;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idwt53_row.sv
// -----------------------------------------------------------------------------
// tb_idwt53_row
//   Four engines (LEN 4, 2, 8, 64) share one behavioural sample RAM; a select
//   routes the active engine onto the RAM. Stimulus loads a row, pushes the
//   expected write sequence (evens, then odds) into a scoreboard queue and
//   starts the engine; an independent monitor pops and compares on each write.
// -----------------------------------------------------------------------------
module tb_idwt53_row;

  localparam int W  = 16;
  localparam int AW = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic          clk;
  logic          reset;
  logic [3:0]    start_v;
  logic [AW-1:0] base_addr;
  logic [W-1:0]  rd_data;

  logic [3:0]    busy_v, done_v, rd_en_v, wr_en_v;
  logic [AW-1:0] rd_addr_v [4];
  logic [AW-1:0] wr_addr_v [4];
  logic [W-1:0]  wr_data_v [4];

  logic [1:0]    sel;
  logic          m_busy, m_done, m_rd_en, m_wr_en;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [W-1:0]  m_wr_data;

  logic [W-1:0]  ram [64];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;

  wr_t exp_q[$];
  int  checks;
  int  errors;
  int  done_cnt;
  int  overlap_cnt;
  bit  mon_en;

  int  coef [64];
  int  expx [64];
  int  xs   [64];

  // ---------------------------------------------------------------------------
  // Engines under test
  // ---------------------------------------------------------------------------
  idwt53_row #(.WIDTH(W), .ADDR_W(AW), .LEN(4)) u_len4 (
    .clk(clk), .reset(reset), .start(start_v[0]), .base_addr(base_addr),
    .busy(busy_v[0]), .done(done_v[0]), .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]),
    .rd_data(rd_data), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0])
  );

  idwt53_row #(.WIDTH(W), .ADDR_W(AW), .LEN(2)) u_len2 (
    .clk(clk), .reset(reset), .start(start_v[1]), .base_addr(base_addr),
    .busy(busy_v[1]), .done(done_v[1]), .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]),
    .rd_data(rd_data), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1])
  );

  idwt53_row #(.WIDTH(W), .ADDR_W(AW), .LEN(8)) u_len8 (
    .clk(clk), .reset(reset), .start(start_v[2]), .base_addr(base_addr),
    .busy(busy_v[2]), .done(done_v[2]), .rd_en(rd_en_v[2]), .rd_addr(rd_addr_v[2]),
    .rd_data(rd_data), .wr_en(wr_en_v[2]), .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2])
  );

  idwt53_row #(.WIDTH(W), .ADDR_W(AW), .LEN(64)) u_len64 (
    .clk(clk), .reset(reset), .start(start_v[3]), .base_addr(base_addr),
    .busy(busy_v[3]), .done(done_v[3]), .rd_en(rd_en_v[3]), .rd_addr(rd_addr_v[3]),
    .rd_data(rd_data), .wr_en(wr_en_v[3]), .wr_addr(wr_addr_v[3]), .wr_data(wr_data_v[3])
  );

  always_comb begin
    m_busy    = busy_v[sel];
    m_done    = done_v[sel];
    m_rd_en   = rd_en_v[sel];
    m_rd_addr = rd_addr_v[sel];
    m_wr_en   = wr_en_v[sel];
    m_wr_addr = wr_addr_v[sel];
    m_wr_data = wr_data_v[sel];
  end

  // Synchronous RAM: one-cycle read latency, bench preload has priority.
  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (m_wr_en) begin
      ram[m_wr_addr] <= m_wr_data;
    end
    if (m_rd_en) begin
      rd_data <= ram[m_rd_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares each write against the scoreboard, counts done pulses.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (m_done) done_cnt++;
    if (m_rd_en && m_wr_en) overlap_cnt++;
    if (mon_en && m_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d with nothing expected",
                 m_wr_addr, $signed(m_wr_data));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", m_wr_addr, e.addr);
        check("wr_data", $signed(m_wr_data), $signed(e.data));
      end
    end
  end

  task automatic set_vec4(input int c0, input int c1, input int c2, input int c3,
                          input int x0, input int x1, input int x2, input int x3);
    coef[0] = c0; coef[1] = c1; coef[2] = c2; coef[3] = c3;
    expx[0] = x0; expx[1] = x1; expx[2] = x2; expx[3] = x3;
  endtask

  // Forward 5/3 lifting of xs[0..len-1] into coef; expected output is xs.
  task automatic forward_lift(input int len);
    int l;
    int r;
    for (int i = 1; i < len; i += 2) begin
      r = (i + 1 == len) ? xs[len-2] : xs[i+1];
      coef[i] = xs[i] - ((xs[i-1] + r) >>> 1);
    end
    for (int i = 0; i < len; i += 2) begin
      l = (i == 0) ? coef[1] : coef[i-1];
      r = coef[i+1];
      coef[i] = xs[i] + ((l + r + 2) >>> 2);
    end
    for (int i = 0; i < len; i++) expx[i] = xs[i];
  endtask

  task automatic load_ram(input int len, input int base);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = AW'(base + k);
      ld_data = W'(coef[k]);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_row(input int s, input int len, input int base, input bit extra);
    int  cyc;
    int  limit;
    wr_t e;
    load_ram(len, base);
    for (int i = 0; i < len; i += 2) begin
      e.addr = AW'(base + i);
      e.data = W'(expx[i]);
      exp_q.push_back(e);
    end
    for (int i = 1; i < len; i += 2) begin
      e.addr = AW'(base + i);
      e.data = W'(expx[i]);
      exp_q.push_back(e);
    end
    sel      = 2'(s);
    done_cnt = 0;
    @(negedge clk);
    base_addr  = AW'(base);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    cyc   = 1;
    limit = 5 * len + 20;
    while (!m_done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start_v[s] = (extra && cyc == 10);
    end
    check($sformatf("done_latency_len%0d", len), cyc, 5 * len + 1);
    if (extra) begin
      start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
      check("start_in_done_ignored", m_busy, 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt, 1);
    for (int k = 0; k < len; k++) begin
      check($sformatf("ram_x%0d", k), $signed(ram[AW'(base + k)]), expx[k]);
    end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int cyc;
    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    overlap_cnt = 0;
    mon_en      = 1'b1;
    reset       = 1'b1;
    start_v     = '0;
    base_addr   = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    sel         = 2'd0;

    repeat (3) @(negedge clk);
    check("rst_busy",    m_busy,    0);
    check("rst_done",    m_done,    0);
    check("rst_rd_en",   m_rd_en,   0);
    check("rst_wr_en",   m_wr_en,   0);
    check("rst_rd_addr", m_rd_addr, 0);
    check("rst_wr_addr", m_wr_addr, 0);
    check("rst_wr_data", m_wr_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic row: [216,2,217,2] -> [215,217,216,218], done 21 cycles after start.
    set_vec4(216, 2, 217, 2, 215, 217, 216, 218);
    run_row(0, 4, 0, 1'b0);

    // Negative neighbour sums: (-3-3+2)>>>2 = -1.
    set_vec4(0, -3, 0, -3, 1, -2, 1, -2);
    run_row(0, 4, 10, 1'b0);

    // Shortest row: both neighbours mirror onto the single partner sample.
    coef[0] = 10; coef[1] = 4;
    expx[0] = 8;  expx[1] = 12;
    run_row(1, 2, 5, 1'b0);

    // Round trip of a 64-sample ramp.
    for (int i = 0; i < 64; i++) xs[i] = 55 + i;
    forward_lift(64);
    run_row(3, 64, 0, 1'b0);

    // Round trip across the address wrap (60..63, 0..3).
    xs[0] = 100;  xs[1] = -50; xs[2] = 30; xs[3] = 7;
    xs[4] = -200; xs[5] = 1000; xs[6] = 3; xs[7] = -4;
    forward_lift(8);
    run_row(2, 8, 60, 1'b0);

    // Reset in cycle 7 of a row aborts at once and produces no done.
    set_vec4(216, 2, 217, 2, 215, 217, 216, 218);
    load_ram(4, 0);
    sel      = 2'd0;
    mon_en   = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    base_addr  = '0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 1;
    repeat (6) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_pre_busy",  m_busy,  1);
    check("abort_pre_rd_en", m_rd_en, 1);
    reset = 1'b1;
    #1;
    check("abort_busy",  m_busy,  0);
    check("abort_rd_en", m_rd_en, 0);
    check("abort_wr_en", m_wr_en, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    mon_en = 1'b1;
    run_row(0, 4, 0, 1'b0);

    // Start pulsed mid-row and again in the DONE cycle: one row, one done.
    set_vec4(216, 2, 217, 2, 215, 217, 216, 218);
    run_row(0, 4, 20, 1'b1);

    check("rd_wr_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
